// File: rtl/uart_lite_responder.sv
// uart_lite_responder: 16550-subset UART register responder, 8N1, no FIFOs.
// Ports: clk_33M, rstn (async low), cs/wr/rd/a/din/dout host bus, intr, sin, sout.
// Optional: UART_LITE_LOOPBACK_EN makes MCR[4] loop TX into RX.
`timescale 1ns/1ps
module uart_lite_responder #(
  parameter logic [15:0] DIV_RESET      = 16'h0011,
  parameter int          RX_SYNC_STAGES = 2
) (
  input  logic       clk_33M,
  input  logic       rstn,
  input  logic       cs,
  input  logic       wr,
  input  logic       rd,
  input  logic [2:0] a,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       intr,
  input  logic       sin,
  output logic       sout
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } bit_st_t;

  logic [7:0]  lcr;
  logic [1:0]  ier;
  logic [4:0]  mcr;
  logic [7:0]  scr;
  logic [15:0] dl;
  logic [7:0]  thr;
  logic        thr_full;
  logic        thre_pend;
  logic        thre_pend_n;
  logic [7:0]  rbr;
  logic        dr;
  logic        oe;
  logic        fe;
  logic        oe_n;
  logic        fe_n;

  logic wr_q;
  logic rd_q;
  logic we;
  logic re;
  logic dlab;
  logic thre;
  logic temt;

  logic wr_thr;
  logic wr_dll;
  logic wr_dlm;
  logic wr_ier;
  logic rd_rbr;
  logic rd_iir;
  logic rd_lsr;

  logic [7:0] lsr;
  logic [7:0] iir;
  logic [7:0] rdata;

  logic [15:0] bcnt;
  logic        tick;

  bit_st_t    tx_st;
  bit_st_t    tx_st_n;
  logic [3:0] tx_tc;
  logic [3:0] tx_tc_n;
  logic [2:0] tx_bit;
  logic [2:0] tx_bit_n;
  logic [7:0] tx_sh;
  logic [7:0] tx_sh_n;
  logic       tx_out;
  logic       tx_out_n;
  logic       tx_load;
  logic       tx_end;

  bit_st_t    rx_st;
  bit_st_t    rx_st_n;
  logic [3:0] rx_tc;
  logic [3:0] rx_tc_n;
  logic [2:0] rx_bit;
  logic [2:0] rx_bit_n;
  logic [7:0] rx_sh;
  logic [7:0] rx_sh_n;
  logic       rx_done;
  logic       rx_ferr;
  logic       rx_end;
  logic       rx_mid;

  logic [RX_SYNC_STAGES-1:0] sync;
  logic rx_in;
  logic rx_s;
  logic rx_prev;
  logic lpbk;

`ifdef UART_LITE_LOOPBACK_EN
  assign lpbk = mcr[4];
`else
  assign lpbk = 1'b0;
`endif

  assign rx_in = lpbk ? tx_out : sin;
  assign sout  = lpbk ? 1'b1 : tx_out;
  assign rx_s  = sync[RX_SYNC_STAGES-1];

  // Bus strobes act only on their rising edge.
  assign we   = cs & wr & ~wr_q;
  assign re   = cs & rd & ~rd_q;
  assign dlab = lcr[7];

  assign wr_thr = we & (a == 3'd0) & ~dlab;
  assign wr_dll = we & (a == 3'd0) & dlab;
  assign wr_dlm = we & (a == 3'd1) & dlab;
  assign wr_ier = we & (a == 3'd1) & ~dlab;
  assign rd_rbr = re & (a == 3'd0) & ~dlab;
  assign rd_iir = re & (a == 3'd2);
  assign rd_lsr = re & (a == 3'd5);

  assign thre = ~thr_full;
  assign temt = thre & (tx_st == S_IDLE);
  assign lsr  = {1'b0, temt, thre, 1'b0,
                 fe, 1'b0, oe, dr};

  always_comb begin
    iir = 8'h01;
    unique case (1'b1)
      ier[0] & dr:        iir = 8'h04;
      ier[1] & thre_pend: iir = 8'h02;
      default:            iir = 8'h01;
    endcase
  end

  always_comb begin
    rdata = 8'h00;
    unique case (a)
      3'd0: rdata = dlab ? dl[7:0] : rbr;
      3'd1: rdata = dlab ? dl[15:8]
                         : {6'b0, ier};
      3'd2: rdata = iir;
      3'd3: rdata = lcr;
      3'd4: rdata = {3'b0, mcr};
      3'd5: rdata = lsr;
      3'd6: rdata = 8'h00;
      3'd7: rdata = scr;
      default: rdata = 8'h00;
    endcase
  end

  // Baud prescaler; a divisor of zero halts both shifters.
  assign tick = (dl != 16'd0) &&
                (bcnt == dl - 16'd1);

  always_ff @(posedge clk_33M or negedge rstn) begin
    if (!rstn) begin
      bcnt <= 16'd0;
    end else if (wr_dll | wr_dlm | tick) begin
      bcnt <= 16'd0;
    end else if (dl != 16'd0) begin
      bcnt <= bcnt + 16'd1;
    end
  end

  assign tx_end = tick && (tx_tc == 4'd15);

  always_comb begin
    tx_st_n  = tx_st;
    tx_tc_n  = tx_tc;
    tx_bit_n = tx_bit;
    tx_sh_n  = tx_sh;
    tx_out_n = tx_out;
    tx_load  = 1'b0;
    if (tx_st != S_IDLE && tick)
      tx_tc_n = tx_tc + 4'd1;
    unique case (tx_st)
      S_IDLE: begin
        tx_out_n = 1'b1;
        if (thr_full) begin
          tx_load  = 1'b1;
          tx_sh_n  = thr;
          tx_tc_n  = 4'd0;
          tx_bit_n = 3'd0;
          tx_out_n = 1'b0;
          tx_st_n  = S_START;
        end
      end
      S_START: begin
        if (tx_end) begin
          tx_out_n = tx_sh[0];
          tx_st_n  = S_DATA;
        end
      end
      S_DATA: begin
        if (tx_end) begin
          if (tx_bit == 3'd7) begin
            tx_out_n = 1'b1;
            tx_st_n  = S_STOP;
          end else begin
            tx_sh_n  = {1'b0, tx_sh[7:1]};
            tx_out_n = tx_sh[1];
            tx_bit_n = tx_bit + 3'd1;
          end
        end
      end
      S_STOP: begin
        if (tx_end) begin
          tx_out_n = 1'b1;
          tx_st_n  = S_IDLE;
        end
      end
      default: tx_st_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_33M or negedge rstn) begin
    if (!rstn) begin
      tx_st  <= S_IDLE;
      tx_tc  <= 4'd0;
      tx_bit <= 3'd0;
      tx_sh  <= 8'h00;
      tx_out <= 1'b1;
    end else begin
      tx_st  <= tx_st_n;
      tx_tc  <= tx_tc_n;
      tx_bit <= tx_bit_n;
      tx_sh  <= tx_sh_n;
      tx_out <= tx_out_n;
    end
  end

  always_ff @(posedge clk_33M or negedge rstn) begin
    if (!rstn) begin
      sync    <= '1;
      rx_prev <= 1'b1;
    end else begin
      sync    <= {sync[RX_SYNC_STAGES-2:0], rx_in};
      rx_prev <= rx_s;
    end
  end

  // Start is confirmed half a bit in; data/stop are sampled mid-bit.
  assign rx_mid = tick && (rx_tc == 4'd7);
  assign rx_end = tick && (rx_tc == 4'd15);

  always_comb begin
    rx_st_n  = rx_st;
    rx_tc_n  = rx_tc;
    rx_bit_n = rx_bit;
    rx_sh_n  = rx_sh;
    rx_done  = 1'b0;
    rx_ferr  = 1'b0;
    if (rx_st != S_IDLE && tick)
      rx_tc_n = rx_tc + 4'd1;
    unique case (rx_st)
      S_IDLE: begin
        if (rx_prev & ~rx_s) begin
          rx_tc_n = 4'd0;
          rx_st_n = S_START;
        end
      end
      S_START: begin
        if (rx_mid) begin
          if (!rx_s) begin
            rx_tc_n  = 4'd0;
            rx_bit_n = 3'd0;
            rx_st_n  = S_DATA;
          end else begin
            rx_st_n  = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (rx_end) begin
          rx_sh_n  = {rx_s, rx_sh[7:1]};
          rx_bit_n = rx_bit + 3'd1;
          if (rx_bit == 3'd7)
            rx_st_n = S_STOP;
        end
      end
      S_STOP: begin
        if (rx_end) begin
          rx_done = 1'b1;
          rx_ferr = ~rx_s;
          rx_st_n = S_IDLE;
        end
      end
      default: rx_st_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_33M or negedge rstn) begin
    if (!rstn) begin
      rx_st  <= S_IDLE;
      rx_tc  <= 4'd0;
      rx_bit <= 3'd0;
      rx_sh  <= 8'h00;
    end else begin
      rx_st  <= rx_st_n;
      rx_tc  <= rx_tc_n;
      rx_bit <= rx_bit_n;
      rx_sh  <= rx_sh_n;
    end
  end

  // Clears first, sets last: a same-cycle event wins over a read clear.
  always_comb begin
    thre_pend_n = thre_pend;
    oe_n        = oe;
    fe_n        = fe;
    if ((wr_thr & thre) ||
        (rd_iir && iir == 8'h02))
      thre_pend_n = 1'b0;
    if (tx_load ||
        (wr_ier & ~ier[1] & din[1] & thre))
      thre_pend_n = 1'b1;
    if (rd_lsr) begin
      oe_n = 1'b0;
      fe_n = 1'b0;
    end
    if (rx_done & dr & ~rd_rbr)
      oe_n = 1'b1;
    if (rx_done & rx_ferr)
      fe_n = 1'b1;
  end

  always_ff @(posedge clk_33M or negedge rstn) begin
    if (!rstn) begin
      wr_q      <= 1'b0;
      rd_q      <= 1'b0;
      lcr       <= 8'h00;
      ier       <= 2'b00;
      mcr       <= 5'h00;
      scr       <= 8'h00;
      dl        <= DIV_RESET;
      thr       <= 8'h00;
      thr_full  <= 1'b0;
      thre_pend <= 1'b0;
      rbr       <= 8'h00;
      dr        <= 1'b0;
      oe        <= 1'b0;
      fe        <= 1'b0;
      dout      <= 8'h00;
      intr      <= 1'b0;
    end else begin
      wr_q      <= cs & wr;
      rd_q      <= cs & rd;
      thre_pend <= thre_pend_n;
      oe        <= oe_n;
      fe        <= fe_n;
      intr      <= (ier[0] & dr) |
                   (ier[1] & thre_pend);
      if (cs & rd)
        dout <= rdata;
      if (wr_dll)
        dl[7:0] <= din;
      if (wr_dlm)
        dl[15:8] <= din;
      if (wr_ier)
        ier <= din[1:0];
      if (we && a == 3'd3)
        lcr <= din;
      if (we && a == 3'd4)
        mcr <= din[4:0];
      if (we && a == 3'd7)
        scr <= din;
      if (tx_load) begin
        thr_full <= 1'b0;
      end else if (wr_thr & thre) begin
        thr_full <= 1'b1;
        thr      <= din;
      end
      if (rx_done) begin
        rbr <= rx_sh;
        dr  <= 1'b1;
      end else if (rd_rbr) begin
        dr  <= 1'b0;
      end
    end
  end

endmodule
